// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// ----------------
// Hazard and stall controller for the 5-stage MIPS pipeline. It watches the
// instructions in ID and EX and drives the load enables, flushes, bubbles and
// holds of the PC, IF/ID, ID/EX and EX/MEM registers. It handles:
//   - load-use stalls (one bubble, forwarding covers the rest),
//   - taken branches resolved in EX and jumps resolved in ID (redirects),
//   - multi-cycle multiplies that stay in EX for MUL_LATENCY cycles,
//   - a level-sensitive debug halt that freezes the front of the pipe.
// Two saturating performance counters track stall and flush cycles.
//
// Ports
//   Clk, Reset                 clock; synchronous active-high reset
//   ID_Rs, ID_Rt, ID_UsesRt    source registers of the ID instruction
//   ID_Jump                    jump decoded in ID
//   EX_MemRead, EX_WriteReg    load size and destination of the EX instruction
//   EX_IsMul                   EX instruction is a multiply
//   BranchTaken                EX branch resolved taken
//   DbgHalt                    debug freeze request
//   PCWrite, IF_ID_Write       load enables
//   IF_ID_Flush                zero IF/ID at next edge
//   ID_EX_Bubble, ID_EX_Hold   ID/EX bubble insert / hold
//   EX_MEM_Bubble              zero controls into EX/MEM at next edge
//   State                      0=RUN, 1=MULWAIT, 2=HALT
//   StallCycles, FlushCount    saturating performance counters

module hazard_sequencer #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 3,
    parameter int PERF_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic              ID_UsesRt,
    input  logic              ID_Jump,
    input  logic [1:0]        EX_MemRead,
    input  logic [4:0]        EX_WriteReg,
    input  logic              EX_IsMul,
    input  logic              BranchTaken,
    input  logic              DbgHalt,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Bubble,
    output logic              ID_EX_Hold,
    output logic              EX_MEM_Bubble,
    output logic [1:0]        State,
    output logic [PERF_W-1:0] StallCycles,
    output logic [PERF_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MULWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic             load_use;

    // Register x0 is never a real dependency, so a load to it never stalls.
    assign load_use = (EX_MemRead != 2'b00) && (EX_WriteReg != 5'd0) &&
                      ((EX_WriteReg == ID_Rs) ||
                       (ID_UsesRt && (EX_WriteReg == ID_Rt)));

    assign State = state_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        ID_EX_Hold    = 1'b0;
        EX_MEM_Bubble = 1'b0;
        state_d       = state_q;
        mul_cnt_d     = mul_cnt_q;

        if (!Reset) begin
            unique case (state_q)
                RUN: begin
                    if (EX_IsMul) begin
                        // Freeze everything behind the multiply; DbgHalt waits
                        // until the multiply has left EX.
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Hold    = 1'b1;
                        EX_MEM_Bubble = 1'b1;
                        mul_cnt_d     = CNT_W'(MUL_LATENCY - 2);
                        state_d       = MULWAIT;
                    end else begin
                        if (BranchTaken) begin
                            // Both younger instructions are on the wrong path.
                            IF_ID_Flush  = 1'b1;
                            ID_EX_Bubble = 1'b1;
                        end else if (load_use) begin
                            PCWrite      = 1'b0;
                            IF_ID_Write  = 1'b0;
                            ID_EX_Bubble = 1'b1;
                        end else if (ID_Jump) begin
                            IF_ID_Flush  = 1'b1;
                        end
                        if (DbgHalt) begin
                            state_d = HALT;
                        end
                    end
                end

                MULWAIT: begin
                    if (mul_cnt_q != '0) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Hold    = 1'b1;
                        EX_MEM_Bubble = 1'b1;
                        mul_cnt_d     = mul_cnt_q - 1'b1;
                    end else begin
                        // Release cycle: defaults let the multiply advance.
                        state_d = RUN;
                    end
                end

                HALT: begin
                    // Frozen front end; the exit cycle still holds, so the
                    // frozen branch/jump/load-use is re-evaluated in RUN.
                    PCWrite       = 1'b0;
                    IF_ID_Write   = 1'b0;
                    ID_EX_Hold    = 1'b1;
                    EX_MEM_Bubble = 1'b1;
                    if (!DbgHalt) begin
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            if (!PCWrite && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 1'b1;
            end
            if (IF_ID_Flush && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end

endmodule
